// File: rtl/serial_subtractor.sv
`default_nettype none
// ============================================================================
// Module   : serial_subtractor
// Purpose  : Bit-serial N-bit subtractor. It computes diff = a - b - bin one
//            bit per clock, LSB first. One full-subtractor cell and a
//            registered borrow do the work, under a start/done handshake.
//            An operation accepted at edge E0 raises done for the cycle
//            after edge E0+WIDTH. The next start can be accepted at edge
//            E0+WIDTH+2.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Parameters
//   WIDTH       operand/result width in bits (legal range 2..32)
// Ports
//   clk         rising-edge clock
//   rst         synchronous, active-high reset
//   start       operation request, sampled only while idle
//   a, b, bin   minuend, subtrahend, borrow-in (captured on the accepted
//               start edge)
//   busy        high while bits are being shifted
//   done        one-cycle pulse, result valid
//   diff        registered result, held until the next completion
//   borrow_out  final borrow (1 when a < b + bin, unsigned)
//   ovf         (only with SERSUB_OVF_EN) signed overflow of a - b
// Optional feature macro: SERSUB_OVF_EN
// ============================================================================
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
`ifdef SERSUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  // Counter wide enough to index bits 0..WIDTH-1.
  localparam int               CNT_W    = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SHIFT = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]       state;
  logic [WIDTH-1:0] a_sr;
  logic [WIDTH-1:0] b_sr;
  logic [WIDTH-1:0] res_sr;
  logic [CNT_W-1:0] cnt;
  logic             br;

  // Full-subtractor cell on the current LSBs.
  logic             d_bit;
  logic             bo_bit;
  logic [WIDTH-1:0] res_next;
  logic             last_bit;

  always_comb begin
    d_bit    = a_sr[0] ^ b_sr[0] ^ br;
    bo_bit   = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
    // The result fills from the top. After WIDTH shifts the first
    // (LSB) difference bit has reached bit 0.
    res_next = {d_bit, res_sr[WIDTH-1:1]};
    last_bit = (cnt == LAST_BIT);
  end

`ifdef SERSUB_OVF_EN
  // Operand sign bits kept for the signed-overflow decision at completion.
  logic a_msb;
  logic b_msb;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      a_sr       <= '0;
      b_sr       <= '0;
      res_sr     <= '0;
      cnt        <= '0;
      br         <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
`ifdef SERSUB_OVF_EN
      a_msb      <= 1'b0;
      b_msb      <= 1'b0;
      ovf        <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            state  <= S_SHIFT;
            a_sr   <= a;
            b_sr   <= b;
            br     <= bin;
            cnt    <= '0;
            res_sr <= '0;
`ifdef SERSUB_OVF_EN
            a_msb  <= a[WIDTH-1];
            b_msb  <= b[WIDTH-1];
`endif
          end
        end

        S_SHIFT: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          br     <= bo_bit;
          cnt    <= cnt + 1'b1;
          res_sr <= res_next;
          if (last_bit) begin
            // Publish the result on the edge that consumes the MSB. The
            // visible outputs stay untouched until then.
            state      <= S_DONE;
            diff       <= res_next;
            borrow_out <= bo_bit;
`ifdef SERSUB_OVF_EN
            ovf        <= (a_msb != b_msb) && (res_next[WIDTH-1] != a_msb);
`endif
          end
        end

        S_DONE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Decoded from registered state, so both are glitch-free.
  assign busy = (state == S_SHIFT);
  assign done = (state == S_DONE);

endmodule
`default_nettype wire
